// File: rtl/wb_stage_queue_if.sv
// Write-back stage bus: MEM handover, regfile write, trace head and
// forwarding lookup grouped into one interface. The master side is the
// pipeline environment and the slave side is the write-back queue.
interface wb_stage_queue_if #(
  parameter int DATA_W = 32
);
  logic              ready_go_mem;
  logic              allow_in;
  logic [31:0]       inst_from_mem;
  logic [31:0]       pc_from_mem;
  logic [DATA_W-1:0] data_to_reg_from_mem;
  logic              reg_en_from_mem;
  logic [4:0]        dest_from_mem;
  logic              trace_ready;
  logic              we;
  logic [4:0]        waddr;
  logic [DATA_W-1:0] wdata;
  logic [31:0]       inst;
  logic [31:0]       pc;
  logic              valid;
  logic [4:0]        query_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [31:0]       stall_cycles;

  modport slave (
    input  ready_go_mem, inst_from_mem, pc_from_mem, data_to_reg_from_mem,
           reg_en_from_mem, dest_from_mem, trace_ready, query_addr,
    output allow_in, we, waddr, wdata, inst, pc, valid, fwd_hit, fwd_data,
           stall_cycles
  );

  modport master (
    output ready_go_mem, inst_from_mem, pc_from_mem, data_to_reg_from_mem,
           reg_en_from_mem, dest_from_mem, trace_ready, query_addr,
    input  allow_in, we, waddr, wdata, inst, pc, valid, fwd_hit, fwd_data,
           stall_cycles
  );
endinterface

// File: rtl/wb_stage_queue.sv
// Write-back stage queue: buffers up to DEPTH retiring instructions and
// retires the head only when the trace consumer accepts it. Counts cycles
// in which a head entry waits on the trace consumer.
// Optional feature macro: WB_FORWARD_EN builds the forwarding lookup over
// all buffered results; without it fwd_hit/fwd_data are tied to zero.
module wb_stage_queue #(
  parameter int          DATA_W   = 32,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h1bfffffc
) (
  input logic            clk,
  input logic            reset,
  wb_stage_queue_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [31:0]       inst_q   [DEPTH];
  logic [31:0]       pc_q     [DEPTH];
  logic [DATA_W-1:0] data_q   [DEPTH];
  logic              reg_en_q [DEPTH];
  logic [4:0]        dest_q   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [31:0]      stall_cnt;

  logic head_valid;
  logic push;
  logic commit;

  assign head_valid = (count != '0);
  // Registered count only, so a same-cycle commit never frees a slot.
  assign bus.allow_in = (count != FULL_CNT);
  assign push   = bus.ready_go_mem & bus.allow_in;
  // Commit is suppressed while reset is sampled so no write escapes.
  assign commit = head_valid & bus.trace_ready & ~reset;

  // Head entry toward regfile and trace port; fixed idle values when empty.
  always_comb begin
    bus.valid = head_valid;
    bus.inst  = '0;
    bus.pc    = RESET_PC;
    bus.waddr = '0;
    bus.wdata = '0;
    bus.we    = 1'b0;
    if (head_valid) begin
      bus.inst  = inst_q[rd_ptr];
      bus.pc    = pc_q[rd_ptr];
      bus.waddr = dest_q[rd_ptr];
      bus.wdata = data_q[rd_ptr];
      bus.we    = commit & reg_en_q[rd_ptr];
    end
  end

  assign bus.stall_cycles = stall_cnt;

  // Pointer, occupancy and stall-counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      stall_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (commit) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !commit) begin
        count <= count + (PTR_W + 1)'(1);
      end else if (!push && commit) begin
        count <= count - (PTR_W + 1)'(1);
      end
      if (head_valid && !bus.trace_ready) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[wr_ptr]   <= bus.inst_from_mem;
      pc_q[wr_ptr]     <= bus.pc_from_mem;
      data_q[wr_ptr]   <= bus.data_to_reg_from_mem;
      reg_en_q[wr_ptr] <= bus.reg_en_from_mem;
      dest_q[wr_ptr]   <= bus.dest_from_mem;
    end
  end

`ifdef WB_FORWARD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    fwd_idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PTR_W'(i);
      if (((PTR_W + 1)'(i) < count) && (bus.query_addr != 5'd0) &&
          reg_en_q[fwd_idx] && (dest_q[fwd_idx] == bus.query_addr)) begin
        bus.fwd_hit  = 1'b1;
        bus.fwd_data = data_q[fwd_idx];
      end
    end
  end
`else
  logic unused_query;

  assign unused_query = ^bus.query_addr;
  assign bus.fwd_hit  = 1'b0;
  assign bus.fwd_data = '0;
`endif

endmodule

// File: doc/wb_stage_queue.md
# wb_stage_queue

Parametrised write-back stage between MEM and the register file / debug trace port. It buffers up to DEPTH retiring instructions in a FIFO. It retires one per cycle only when the trace consumer accepts it, so trace capture can back-pressure the pipeline. It also gives ID a forwarding lookup over all buffered results and counts trace-stall cycles.

## Interface
- DATA_W, 32, width of write-back data.
- DEPTH, 2, FIFO entries; power of two, 2..16.
- RESET_PC, 32'h1bfffffc, pc output value while the queue is empty.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ready_go_mem  in  1  MEM has a valid instruction to hand over this cycle.
- allow_in  out  1  stage can accept an entry this cycle.
- inst_from_mem  in  32  instruction word.
- pc_from_mem  in  32  instruction pc.
- data_to_reg_from_mem  in  DATA_W  write-back data.
- reg_en_from_mem  in  1  instruction writes a register.
- dest_from_mem  in  5  destination register.
- trace_ready  in  1  trace consumer accepts the head entry this cycle.
- we  out  1  regfile write enable.
- waddr  out  5  regfile write address.
- wdata  out  DATA_W  regfile write data.
- inst  out  32  head instruction for trace.
- pc  out  32  head pc for trace.
- valid  out  1  head entry present.
- query_addr  in  5  ID source register to look up.
- fwd_hit  out  1  query matched a buffered result.
- fwd_data  out  DATA_W  data of the youngest matching entry.
- stall_cycles  out  32  count of trace-stall cycles.

## Operation
- Circular FIFO: write pointer, read pointer, count; pointers wrap modulo DEPTH.
- Push:
  - push = ready_go_mem & allow_in.
  - Entry stores {inst, pc, data, reg_en, dest}.
- allow_in = (count != DEPTH).
  - Depends on registered count only.
  - A pop in the same cycle does not free a slot for a push when the queue is full.
- Head outputs:
  - valid = (count != 0).
  - inst, pc, waddr, wdata come from the read-pointer entry.
  - When empty: inst=0, pc=RESET_PC, waddr=0, wdata=0.
- Commit:
  - commit = valid & trace_ready.
  - we = commit & head.reg_en.
  - On commit, the read pointer advances and the entry is discarded.
- Push and commit in the same cycle, queue not full: both happen and count is unchanged.
- Push into an empty queue: head is visible the next cycle, never the same cycle.
- Stall counter:
  - stall_cycles increments when valid & !trace_ready.
  - Wraps at 2^32.
  - Never otherwise cleared except by reset.
- Reset:
  - Clears count and pointers; all entries are lost with no write.
  - stall_cycles = 0, valid = 0, we = 0, allow_in = 1 in the cycle after reset is sampled.

## Timing
- MEM-to-head latency: 1 cycle.
- The head-to-regfile write is combinational in the commit cycle.
- Throughput: one push and one commit per cycle.
- The full queue blocks MEM for at least one cycle after a commit frees a slot.
- trace_ready may toggle any cycle.
  - While it is low, the head outputs are stable.
  - The FIFO holds its contents.
- No combinational path from trace_ready to allow_in.
- fwd_hit/fwd_data are combinational from query_addr and the stored entries.
- The incoming MEM entry is not searched by the forwarding lookup.

## Configuration
- WB_FORWARD_EN defined:
  - fwd_hit = 1 when query_addr != 0 and any valid entry has reg_en=1 and dest == query_addr. The search includes the head being committed this cycle.
  - fwd_data comes from the youngest such entry, i.e. the one closest to the write pointer.
- WB_FORWARD_EN undefined:
  - No search logic is built.
  - fwd_hit = 0 and fwd_data = 0 constantly.
  - ID must stall on any buffered destination conflict by other means.

## Test plan
- Reset, then trace_ready=1, then one push (pc=0x1c000000, dest=5, data=0x12345678, reg_en=1) -> next cycle valid=1, we=1, waddr=5, wdata=0x12345678; following cycle valid=0, pc=0x1bfffffc.
- trace_ready=0, push 3 entries with DEPTH=2 -> allow_in=0 after the second push; the third is held by MEM; stall_cycles increases 1 per cycle while valid.
- Full queue, then trace_ready=1 for 4 cycles with MEM pushing continuously -> commits in pc order with no loss or duplication; allow_in stays low in the first commit cycle.
- With WB_FORWARD_EN, entries dest=7 data=0xA then dest=7 data=0xB buffered, query_addr=7 -> fwd_hit=1, fwd_data=0xB; query_addr=0 -> fwd_hit=0; entry with reg_en=0 -> no hit.
- reset asserted with 2 entries buffered and trace_ready=1 -> no we in or after the reset cycle; count=0, stall_cycles=0, allow_in=1.
- Simultaneous push and commit for 16 consecutive cycles with DEPTH=4 -> count constant, pointer wrap verified, trace pc sequence matches push order.
